// File: rtl/mssd_param.sv
// Parametrised serial demultiplexer: decodes start/addr/len/payload/[parity]/stop
// frames from one serial line and forwards each payload bit to the addressed channel.
module mssd_param #(
   parameter int ADDR_W    = 2,
   parameter int LEN_W     = 4,
   parameter int PARITY_EN = 0
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     serIn,
   output logic [(1<<ADDR_W)-1:0]   out,
   output logic [(1<<ADDR_W)-1:0]   outValid,
   output logic                     busy,
   output logic                     frameDone,
   output logic                     error,
   output logic                     parityErr
);

   localparam int NCH   = 1 << ADDR_W;
   localparam int CNT_W = (ADDR_W > LEN_W) ? ADDR_W : LEN_W;

   typedef enum logic [2:0] {IDLE, ADDR, LEN, DATA, PAR, STOP, ERR} state_t;

   state_t            state_reg, state_next;
   logic [CNT_W-1:0]  cnt_reg;
   logic [ADDR_W-1:0] addr_reg;
   logic [LEN_W-1:0]  len_reg;
   logic              par_reg;
   logic [NCH-1:0]    out_reg, valid_reg;
   logic              busy_reg, done_reg, error_reg, perr_reg;

   logic [ADDR_W:0]   addr_sh;
   logic [LEN_W:0]    len_sh;
   logic [NCH-1:0]    chan_sel;
   logic              last_bit;

   assign addr_sh = {addr_reg, serIn};
   assign len_sh  = {len_reg, serIn};

   generate
      for (genvar gi = 0; gi < NCH; gi++) begin : g_sel
         assign chan_sel[gi] = (addr_reg == ADDR_W'(gi));
      end
   endgenerate

   // Counter runs 0..len, so a len of all ones never needs more than LEN_W bits.
   always_comb begin
      last_bit = 1'b0;
      case (state_reg)
         ADDR:    last_bit = (cnt_reg == CNT_W'(ADDR_W - 1));
         LEN:     last_bit = (cnt_reg == CNT_W'(LEN_W - 1));
         DATA:    last_bit = (cnt_reg == CNT_W'(len_reg));
         default: last_bit = 1'b0;
      endcase
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE: if (!serIn) state_next = ADDR;
         ADDR: if (last_bit) state_next = LEN;
         LEN:  if (last_bit) state_next = DATA;
         DATA: if (last_bit) state_next = (PARITY_EN != 0) ? PAR : STOP;
         PAR:  state_next = STOP;
         STOP: state_next = serIn ? IDLE : ERR;
         ERR:  if (serIn) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg <= IDLE;
         cnt_reg   <= '0;
         addr_reg  <= '0;
         len_reg   <= '0;
         par_reg   <= 1'b0;
         out_reg   <= '0;
         valid_reg <= '0;
         busy_reg  <= 1'b0;
         done_reg  <= 1'b0;
         error_reg <= 1'b0;
         perr_reg  <= 1'b0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= (state_next != state_reg) ? '0 : cnt_reg + CNT_W'(1);
         if (state_reg == ADDR) addr_reg <= addr_sh[ADDR_W-1:0];
         if (state_reg == LEN) begin
            len_reg <= len_sh[LEN_W-1:0];
            par_reg <= 1'b0;
         end
         if (state_reg == DATA) par_reg <= par_reg ^ serIn;

         out_reg   <= '0;
         valid_reg <= '0;
         if (state_reg == DATA) begin
            valid_reg <= chan_sel;
            out_reg   <= chan_sel & {NCH{serIn}};
         end

         busy_reg <= (state_reg != IDLE);
         done_reg <= (state_reg == STOP) && serIn;
         perr_reg <= (state_reg == PAR) && (par_reg ^ serIn);

         // Error latches on a bad stop bit and only clears once the line idles high.
         if (state_reg == STOP && !serIn)
            error_reg <= 1'b1;
         else if (state_reg == ERR && serIn)
            error_reg <= 1'b0;
      end
   end

   assign out       = out_reg;
   assign outValid  = valid_reg;
   assign busy      = busy_reg;
   assign frameDone = done_reg;
   assign error     = error_reg;
   assign parityErr = perr_reg;

endmodule

// File: tb/tb_mssd_param.sv
// Directed bench for mssd_param: three instances (defaults, parity on, 3/5-bit fields)
// driven with hand-built frames; per-cycle monitors tally payload bits per channel.
module tb_mssd_param;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic ser0 = 1'b1, ser1 = 1'b1, ser2 = 1'b1;

   logic [3:0] out0, ov0, out1, ov1;
   logic [7:0] out2, ov2;
   logic       busy0, fd0, err0, pe0;
   logic       busy1, fd1, err1, pe1;
   logic       busy2, fd2, err2, pe2;

   always #5 clk = ~clk;

   mssd_param #(.ADDR_W(2), .LEN_W(4), .PARITY_EN(0)) u_def (
      .clk(clk), .rst(rst), .serIn(ser0), .out(out0), .outValid(ov0),
      .busy(busy0), .frameDone(fd0), .error(err0), .parityErr(pe0));

   mssd_param #(.ADDR_W(2), .LEN_W(4), .PARITY_EN(1)) u_par (
      .clk(clk), .rst(rst), .serIn(ser1), .out(out1), .outValid(ov1),
      .busy(busy1), .frameDone(fd1), .error(err1), .parityErr(pe1));

   mssd_param #(.ADDR_W(3), .LEN_W(5), .PARITY_EN(0)) u_wide (
      .clk(clk), .rst(rst), .serIn(ser2), .out(out2), .outValid(ov2),
      .busy(busy2), .frameDone(fd2), .error(err2), .parityErr(pe2));

   logic [7:0] ovw [3];
   logic [7:0] outw[3];
   logic       fdw [3];
   logic       pew [3];
   logic       errw[3];
   assign ovw[0] = {4'b0, ov0};  assign outw[0] = {4'b0, out0};
   assign ovw[1] = {4'b0, ov1};  assign outw[1] = {4'b0, out1};
   assign ovw[2] = ov2;          assign outw[2] = out2;
   assign fdw[0] = fd0;  assign fdw[1] = fd1;  assign fdw[2] = fd2;
   assign pew[0] = pe0;  assign pew[1] = pe1;  assign pew[2] = pe2;
   assign errw[0] = err0; assign errw[1] = err1; assign errw[2] = err2;

   int          n_checks = 0;
   int          n_fail   = 0;
   int          vcnt[3][8];
   logic [31:0] dat [3][8];
   int          fdn[3], pen[3], bad[3], errc[3];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic clear_mon();
      for (int i = 0; i < 3; i++) begin
         fdn[i] = 0; pen[i] = 0; bad[i] = 0; errc[i] = 0;
         for (int c = 0; c < 8; c++) begin
            vcnt[i][c] = 0;
            dat[i][c]  = '0;
         end
      end
   endtask

   function automatic int total(input int i);
      int s = 0;
      for (int c = 0; c < 8; c++) s += vcnt[i][c];
      return s;
   endfunction

   // One clock: drive the three lines, sample 1 ns after the edge, update tallies.
   task automatic step(input logic b0, input logic b1, input logic b2);
      ser0 = b0; ser1 = b1; ser2 = b2;
      @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) begin
         if ($countones(ovw[i]) > 1 || (outw[i] & ~ovw[i]) != 8'h00) bad[i]++;
         for (int c = 0; c < 8; c++) begin
            if (ovw[i][c]) begin
               vcnt[i][c]++;
               dat[i][c] = {dat[i][c][30:0], outw[i][c]};
            end
         end
         if (fdw[i])  fdn[i]++;
         if (pew[i])  pen[i]++;
         if (errw[i]) errc[i]++;
      end
   endtask

   task automatic send(input int inst, input logic [63:0] bits, input int n);
      for (int k = n - 1; k >= 0; k--)
         step(inst == 0 ? bits[k] : 1'b1,
              inst == 1 ? bits[k] : 1'b1,
              inst == 2 ? bits[k] : 1'b1);
      $display("tx inst=%0d bits=%0d data=%0h", inst, n, bits);
   endtask

   initial begin
      clear_mon();
      #2 rst = 1'b0;
      #1;
      check("reset_outputs", {24'b0, out0, ov0, busy0, fd0, err0, pe0}, 32'h0);
      check("reset_wide", {16'b0, out2, ov2}, 32'h0);
      @(posedge clk); #1;
      rst = 1'b1;
      step(1, 1, 1);
      clear_mon();

      // Frame to channel 2, 4-bit payload 1011.
      step(0, 1, 1);
      check("busy_lag_start", busy0, 1'b0);
      send(0, 64'b10_0011_1011_1, 11);
      check("t1_done_pulse", fd0, 1'b1);
      check("t1_busy_at_done", busy0, 1'b1);
      check("t1_ch2_count", vcnt[0][2], 4);
      check("t1_ch2_data", dat[0][2], 32'hB);
      check("t1_other_ch", total(0) - vcnt[0][2], 0);
      check("t1_onehot", bad[0], 0);
      check("t1_error", errc[0], 0);
      step(1, 1, 1);
      check("t1_done_once", fdn[0], 1);
      check("t1_busy_fall", busy0, 1'b0);

      // Bad stop bit, line low 3 more cycles, then idle.
      clear_mon();
      send(0, 64'b0_11_0000_1_0, 9);
      check("t2_error_set", err0, 1'b1);
      step(0, 1, 1); step(0, 1, 1); step(0, 1, 1);
      check("t2_error_held", errc[0], 4);
      step(1, 1, 1);
      check("t2_error_clear", err0, 1'b0);
      step(1, 1, 1);
      check("t2_no_done", fdn[0], 0);
      check("t2_ch3_count", vcnt[0][3], 1);
      check("t2_ch3_data", dat[0][3], 32'h1);

      // Parity enabled: payload 110 has even parity 0.
      clear_mon();
      send(1, 64'b0_01_0010_110_1_1, 12);
      check("t3_pe_low_after", pe1, 1'b0);
      check("t3_pe_count", pen[1], 1);
      check("t3_done", fdn[1], 1);
      check("t3_ch1_data", dat[1][1], 32'h6);
      check("t3_ch1_count", vcnt[1][1], 3);
      clear_mon();
      send(1, 64'b0_01_0010_110_0_1, 12);
      check("t3b_pe_count", pen[1], 0);
      check("t3b_done", fdn[1], 1);

      // Maximum length: 16 payload bits.
      clear_mon();
      send(0, 64'({1'b0, 2'b00, 4'b1111, 16'hA5C3, 1'b1}), 24);
      check("t4_ch0_count", vcnt[0][0], 16);
      check("t4_ch0_data", dat[0][0], 32'hA5C3);
      check("t4_done", fdn[0], 1);
      check("t4_other_ch", total(0) - vcnt[0][0], 0);
      check("t4_onehot", bad[0], 0);

      // Reset in the middle of DATA, then a clean frame.
      clear_mon();
      send(0, 64'b0_10_0111_101, 10);
      check("t5_mid_valid", ov0, 4'b0100);
      rst = 1'b0;
      #1;
      check("t5_reset_clear", {24'b0, out0, ov0, busy0, fd0, err0, pe0}, 32'h0);
      ser0 = 1'b1;
      @(posedge clk); #1;
      rst = 1'b1;
      clear_mon();
      step(1, 1, 1);
      check("t5_idle_after", busy0, 1'b0);
      send(0, 64'b0_01_0001_10_1, 10);
      check("t5_ch1_count", vcnt[0][1], 2);
      check("t5_ch1_data", dat[0][1], 32'h2);
      check("t5_done", fdn[0], 1);

      // Wide instance, back-to-back frames to channels 5 and 0.
      clear_mon();
      send(2, 64'({13'b0_101_00010_011_1, 12'b0_000_00001_11_1}), 25);
      step(1, 1, 1);
      check("t6_ch5_count", vcnt[2][5], 3);
      check("t6_ch5_data", dat[2][5], 32'h3);
      check("t6_ch0_count", vcnt[2][0], 2);
      check("t6_ch0_data", dat[2][0], 32'h3);
      check("t6_other_ch", total(2) - vcnt[2][5] - vcnt[2][0], 0);
      check("t6_done", fdn[2], 2);
      check("t6_onehot", bad[2], 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
